gate_seq_ctrl: RTL and testbench
================================

Name: gate_seq_ctrl

Overview:
- Sequencer/checker for a 2-input XNOR gate datapath (xnor_gate: in_a, in_b -> out_sum).
- On a start pulse, steps the gate through all four input vectors, holding each for DWELL cycles.
- Samples the gate output at the end of each dwell and compares it with the expected XNOR value.
- Reports a done pulse, a mismatch count and pass/fail. Replaces hand-timed stimulus with a reusable self-checking controller.

Parameters:
- DWELL, 5: cycles each vector is held; legal range 2..255.
- CNT_W, 8: width of the dwell counter; must satisfy 2**CNT_W > DWELL.

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  run request; sampled only in IDLE
- busy  out  1  high in APPLY and DONE
- done  out  1  one-cycle pulse at end of run
- out_a  out  1  drives gate in_a
- out_b  out  1  drives gate in_b
- gate_out  in  1  gate out_sum
- vec_idx  out  2  current vector, equal to {out_a,out_b}
- err_cnt  out  3  mismatches in current/last run (0..4)
- pass  out  1  last run had zero mismatches

Behaviour:
- Reset, at the next edge with rst=1, regardless of state:
  - state=IDLE
  - out_a=out_b=0, vec_idx=0
  - busy=0, done=0, err_cnt=0, pass=0
  - dwell counter=0
- States and transitions:
  - IDLE -> APPLY on start=1. At the same edge: vec_idx=0, dwell counter=0, err_cnt cleared.
  - APPLY: holds out_a/out_b = vec_idx bits and increments the dwell counter each cycle.
    - In the cycle where counter==DWELL-1, gate_out is compared with expected=~(out_a^out_b). On mismatch, err_cnt increments at that edge.
    - At the same edge: if vec_idx<3, vec_idx++ and counter=0. If vec_idx==3, go to DONE.
  - DONE: exactly one cycle, with done=1 and busy=1. Then go to IDLE with out_a=out_b=0 and vec_idx=0.
- pass and err_cnt:
  - pass is registered on entry to DONE as (final err_cnt==0), including the last comparison.
  - pass holds until the next accepted start, which clears it to 0.
  - err_cnt holds its final value in IDLE until the next accepted start.
- Vector order: 00, 01, 10, 11. Expected gate outputs: 1, 0, 0, 1.
- Latency: with start accepted at edge 0, APPLY occupies cycles 1..4*DWELL and done is high in cycle 4*DWELL+1. With DWELL=5 that is cycle 21.
- Boundary conditions:
  - start while busy (APPLY or DONE) is ignored; runs cannot be queued.
  - start in the cycle after done is accepted (back-to-back runs).
  - rst mid-run aborts with no done pulse; restart afterwards behaves normally.
  - err_cnt cannot overflow: at most 4 compares per run.
- gate_out is sampled at the last dwell cycle only, so a combinational gate has DWELL-1 cycles to settle.

Optional Feature:
- Macro: GATE_SEQ_ERRLOG_EN.
- Defined:
  - Adds ports first_fail_vld out 1 and first_fail_idx out 2.
  - On the first mismatch of a run, captures vec_idx and sets first_fail_vld=1. Later mismatches do not overwrite.
  - Both are cleared by rst or an accepted start.
- Undefined: the ports and capture logic are absent; all other behaviour is identical.

Decomposition:
- Package gate_seq_pkg:
  - state enum {IDLE, APPLY, DONE}
  - NUM_VEC=4
  - XNOR_TT=4'b1001: expected output indexed by {a,b}
- Sub-module gate_seq_dwell_cnt:
  - CNT_W-bit counter with clear and enable.
  - Output last asserted when count==DWELL-1.

Test Plan:
- Good XNOR gate attached, DWELL=5, start pulse at cycle 0 -> vectors 00/01/10/11 each held 5 cycles, done at cycle 21, err_cnt=0, pass=1.
- Bench drives gate_out=a^b (inverted gate) -> err_cnt=4, pass=0; with ERRLOG, first_fail_idx=0.
- gate_out stuck at 1 -> err_cnt=2 (vectors 01, 10), pass=0; with ERRLOG, first_fail_vld=1 and first_fail_idx=1.
- start pulsed at cycles 0, 7 and 21 -> only one run; the cycle-21 start is ignored (DONE state), single done pulse.
- rst high at cycle 8 -> next edge shows IDLE, out_a=out_b=0, err_cnt=0, no done; a start at cycle 12 completes normally, done at cycle 33.
- Back-to-back: start the cycle after done with a faulty gate after a good run -> err_cnt cleared then counts to 4, pass 1->0.

Source files
------------

// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the XNOR gate sequencer/checker.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int NUM_VEC = 4;

    // Expected XNOR output indexed by {a,b}: 00->1, 01->0, 10->0, 11->1.
    localparam logic [3:0] XNOR_TT = 4'b1001;

endpackage

// File: rtl/gate_seq_dwell_cnt.sv
// Dwell counter: counts cycles a vector has been held; o_last flags the final cycle.
module gate_seq_dwell_cnt #(
    parameter int DWELL = 5,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_last = (r_count == CNT_W'(DWELL - 1));

endmodule

// File: rtl/gate_seq_ctrl.sv
// Steps a 2-input XNOR gate through all four vectors and checks its output.
// Optional first-failure log enabled by defining GATE_SEQ_ERRLOG_EN.
module gate_seq_ctrl
    import gate_seq_pkg::*;
#(
    parameter int DWELL = 5,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       out_a,
    output logic       out_b,
    input  logic       gate_out,
    output logic [1:0] vec_idx,
    output logic [2:0] err_cnt,
    output logic       pass
`ifdef GATE_SEQ_ERRLOG_EN
    ,
    output logic       first_fail_vld,
    output logic [1:0] first_fail_idx
`endif
);

    state_e      r_state;
    state_e      w_next_state;
    logic [1:0]  r_vec_idx;
    logic [2:0]  r_err_cnt;
    logic        r_pass;

    logic        w_last;
    logic        w_start_ok;
    logic        w_cmp;
    logic        w_mismatch;
    logic        w_last_vec;
    logic [2:0]  w_err_next;

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_cmp      = (r_state == APPLY) && w_last;
    assign w_mismatch = w_cmp && (gate_out != XNOR_TT[r_vec_idx]);
    assign w_last_vec = (r_vec_idx == 2'(NUM_VEC - 1));
    assign w_err_next = r_err_cnt + 3'(w_mismatch);

    gate_seq_dwell_cnt #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_start_ok || w_cmp),
        .i_en   (r_state == APPLY),
        .o_last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assignment first so no path leaves w_next_state unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = APPLY;
            APPLY:   if (w_cmp && w_last_vec) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
    end

    // pass is captured with the final compare folded in, so it is valid in the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec_idx <= '0;
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
        end else if (w_start_ok) begin
            r_vec_idx <= '0;
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
        end else if (w_cmp) begin
            r_err_cnt <= w_err_next;
            if (w_last_vec) begin
                r_pass <= (w_err_next == 3'd0);
            end else begin
                r_vec_idx <= r_vec_idx + 2'd1;
            end
        end else if (r_state == DONE) begin
            r_vec_idx <= '0;
        end
    end

    assign vec_idx = r_vec_idx;
    assign out_a   = r_vec_idx[1];
    assign out_b   = r_vec_idx[0];
    assign err_cnt = r_err_cnt;
    assign pass    = r_pass;

`ifdef GATE_SEQ_ERRLOG_EN
    logic       r_ff_vld;
    logic [1:0] r_ff_idx;

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_ff_vld <= 1'b0;
            r_ff_idx <= '0;
        end else if (w_mismatch && !r_ff_vld) begin
            r_ff_vld <= 1'b1;
            r_ff_idx <= r_vec_idx;
        end
    end

    assign first_fail_vld = r_ff_vld;
    assign first_fail_idx = r_ff_idx;
`endif

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Self-checking bench for gate_seq_ctrl: run-level reference model plus directed scenarios.
module tb_gate_seq_ctrl;

    localparam int DWELL   = 5;
    localparam int APPLY_N = 4 * DWELL;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       gate_out;
    logic       busy;
    logic       done;
    logic       out_a;
    logic       out_b;
    logic [1:0] vec_idx;
    logic [2:0] err_cnt;
    logic       pass;
`ifdef GATE_SEQ_ERRLOG_EN
    logic       first_fail_vld;
    logic [1:0] first_fail_idx;
`endif

    // 0: good XNOR gate, 1: inverted (XOR) gate, 2: output stuck at 1
    int gate_mode = 0;

    always #5 clk = ~clk;

    assign gate_out = (gate_mode == 1) ? (out_a ^ out_b) :
                      (gate_mode == 2) ? 1'b1 : ~(out_a ^ out_b);

    gate_seq_ctrl #(.DWELL(DWELL), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .out_a    (out_a),
        .out_b    (out_b),
        .gate_out (gate_out),
        .vec_idx  (vec_idx),
        .err_cnt  (err_cnt),
        .pass     (pass)
`ifdef GATE_SEQ_ERRLOG_EN
        ,
        .first_fail_vld (first_fail_vld),
        .first_fail_idx (first_fail_idx)
`endif
    );

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit gate_fn(input int mode, input int k);
        bit a;
        bit b;
        a = k[1];
        b = k[0];
        if (mode == 1) return a ^ b;
        if (mode == 2) return 1'b1;
        return !(a ^ b);
    endfunction

    function automatic bit xnor_ref(input int k);
        return (k == 0) || (k == 3);
    endfunction

    // Reference model: m_t is the cycle number within a run (1..APPLY_N apply,
    // APPLY_N+1 done), or -1 when idle.
    int m_t      = -1;
    int m_err    = 0;
    bit m_pass   = 1'b0;
    bit m_ff_vld = 1'b0;
    int m_ff_idx = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_t = -1; m_err = 0; m_pass = 1'b0; m_ff_vld = 1'b0; m_ff_idx = 0;
        end else if (m_t < 0) begin
            if (start) begin
                m_t = 1; m_err = 0; m_pass = 1'b0; m_ff_vld = 1'b0; m_ff_idx = 0;
            end
        end else begin
            if (m_t <= APPLY_N && (m_t % DWELL) == 0) begin
                int k;
                k = m_t / DWELL - 1;
                if (gate_fn(gate_mode, k) != xnor_ref(k)) begin
                    m_err++;
                    if (!m_ff_vld) begin
                        m_ff_vld = 1'b1;
                        m_ff_idx = k;
                    end
                end
                if (m_t == APPLY_N) m_pass = (m_err == 0);
            end
            m_t++;
            if (m_t > APPLY_N + 1) m_t = -1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            int e_vec;
            e_vec = (m_t >= 1 && m_t <= APPLY_N) ? (m_t - 1) / DWELL :
                    (m_t == APPLY_N + 1) ? 3 : 0;
            check("busy",    busy,    (m_t >= 1));
            check("done",    done,    (m_t == APPLY_N + 1));
            check("vec_idx", vec_idx, e_vec);
            check("out_a",   out_a,   (e_vec >> 1) & 1);
            check("out_b",   out_b,   e_vec & 1);
            check("err_cnt", err_cnt, m_err);
            check("pass",    pass,    m_pass);
`ifdef GATE_SEQ_ERRLOG_EN
            check("ff_vld",  first_fail_vld, m_ff_vld);
            if (m_ff_vld) check("ff_idx", first_fail_idx, m_ff_idx);
`endif
        end
    end

    // Starts a run in the current cycle (cycle 0); optional extra start pulses at
    // cycles e0/e1. Returns the cycle in which done was seen, or -1 on timeout.
    task automatic run_and_time(input int e0, input int e1, output int done_at);
        int n;
        n       = 0;
        done_at = -1;
        start   = 1'b1;
        while (n < 60) begin
            @(negedge clk);
            n++;
            start = (n == e0) || (n == e1);
            if (done) begin
                done_at = n;
                break;
            end
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        int n;
        int extra_done;

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_err",  err_cnt, 0);
        check("rst_pass", pass, 0);
        check("rst_vec",  vec_idx, 0);
        rst = 1'b0;
        @(negedge clk);

        // Good gate: done in cycle 21, no errors.
        gate_mode = 0;
        run_and_time(-1, -1, d);
        check("good_done_cycle", d, 21);
        check("good_err", err_cnt, 0);
        check("good_pass", pass, 1);

        // Back-to-back start with an inverted gate.
        @(negedge clk);
        gate_mode = 1;
        run_and_time(-1, -1, d);
        check("inv_done_cycle", d, 21);
        check("inv_err", err_cnt, 4);
        check("inv_pass", pass, 0);
`ifdef GATE_SEQ_ERRLOG_EN
        check("inv_ff_idx", first_fail_idx, 0);
`endif

        // Output stuck at 1: vectors 01 and 10 fail.
        @(negedge clk);
        @(negedge clk);
        gate_mode = 2;
        run_and_time(-1, -1, d);
        check("stuck_done_cycle", d, 21);
        check("stuck_err", err_cnt, 2);
        check("stuck_pass", pass, 0);
`ifdef GATE_SEQ_ERRLOG_EN
        check("stuck_ff_vld", first_fail_vld, 1);
        check("stuck_ff_idx", first_fail_idx, 1);
`endif

        // Starts at cycles 7 and 21 (busy) are ignored.
        @(negedge clk);
        gate_mode = 0;
        run_and_time(7, 21, d);
        check("ign_done_cycle", d, 21);
        extra_done = 0;
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
            if (done) extra_done++;
        end
        check("ign_extra_done", extra_done, 0);
        check("ign_busy_after", busy, 0);
        check("ign_pass", pass, 1);

        // Reset at cycle 8 aborts the run; restart at cycle 12 finishes at 33.
        @(negedge clk);
        start = 1'b1;
        n = 0;
        extra_done = 0;
        repeat (12) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            rst   = (n == 8);
            if (done) extra_done++;
            if (n == 9) begin
                check("abort_busy", busy, 0);
                check("abort_out_a", out_a, 0);
                check("abort_out_b", out_b, 0);
                check("abort_err", err_cnt, 0);
            end
        end
        check("abort_no_done", extra_done, 0);
        run_and_time(-1, -1, d);
        check("restart_done_cycle", 12 + d, 33);
        check("restart_pass", pass, 1);

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
